game_state_bank: RTL and testbench

Parametrised, double-buffered game-state register bank for the colour-bounce game. Game logic writes ball position, ball colour, per-platform colour/position and score into a shadow copy at any time. The drawing side sees a stable committed copy that changes only on a commit handshake, typically once per frame. On each commit the previous ball position is kept, so the renderer can erase the old ball and draw the new one.

---
 rtl/game_state_bank.sv | 160 ++++++++++++++++
 tb/tb_game_state_bank.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_bank.sv
// game_state_bank: double-buffered game-state register bank.
// Game logic writes a shadow copy at any time. The renderer sees a
// committed copy that changes only on a commit handshake, once per
// commit_req assertion. Each commit also keeps the previous ball position.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   ball_we/ball_in        - shadow ball position write
//   cball_we/cball_in      - shadow ball colour write
//   plat_we/plat_sel/...   - shadow platform colour+position write
//   score_inc/score_clr    - shadow score saturating increment / clear
//   commit_req             - level request to publish the shadow copy
//   commit_ack             - one-cycle pulse when committed outputs update
//   dirty                  - shadow written since the last commit
//   *_out                  - committed copy (all registered)
module game_state_bank #(
  parameter int unsigned NUM_PLATS = 4,
  parameter int unsigned POS_W     = 7,
  parameter int unsigned COLOR_W   = 3,
  parameter int unsigned BALL_W    = 8,
  parameter int unsigned SCORE_W   = 12
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           ball_we,
  input  logic [BALL_W-1:0]              ball_in,
  input  logic                           cball_we,
  input  logic [COLOR_W-1:0]             cball_in,
  input  logic                           plat_we,
  input  logic [$clog2(NUM_PLATS)-1:0]   plat_sel,
  input  logic [COLOR_W-1:0]             plat_color_in,
  input  logic [POS_W-1:0]               plat_pos_in,
  input  logic                           score_inc,
  input  logic                           score_clr,
  input  logic                           commit_req,
  output logic                           commit_ack,
  output logic                           dirty,
  output logic [BALL_W-1:0]              prev_ball_out,
  output logic [BALL_W-1:0]              curr_ball_out,
  output logic [COLOR_W-1:0]             color_ball_out,
  output logic [NUM_PLATS*COLOR_W-1:0]   color_plats_out,
  output logic [NUM_PLATS*POS_W-1:0]     position_plats_out,
  output logic [SCORE_W-1:0]             score_out
);

  localparam int unsigned SEL_W  = $clog2(NUM_PLATS);
  localparam int unsigned PCOL_W = NUM_PLATS * COLOR_W;
  localparam int unsigned PPOS_W = NUM_PLATS * POS_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_LOW = 1'b1;

  logic [0:0]          state_q, state_d;
  logic                commit_fire_c;

  logic [BALL_W-1:0]   ball_sh_q, ball_sh_d;
  logic [COLOR_W-1:0]  cball_sh_q, cball_sh_d;
  logic [PCOL_W-1:0]   pcol_sh_q, pcol_sh_d;
  logic [PPOS_W-1:0]   ppos_sh_q, ppos_sh_d;
  logic [SCORE_W-1:0]  score_sh_q, score_sh_d;
  logic                plat_hit_c;
  logic                dirty_q, dirty_d;
  logic                ack_q;

  logic [BALL_W-1:0]   prev_ball_q, curr_ball_q;
  logic [COLOR_W-1:0]  color_ball_q;
  logic [PCOL_W-1:0]   color_plats_q;
  logic [PPOS_W-1:0]   pos_plats_q;
  logic [SCORE_W-1:0]  score_q;

  // Commit handshake: one commit per commit_req assertion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    commit_fire_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_req) begin
          commit_fire_c = 1'b1;
          state_d       = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!commit_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow next values; an out-of-range plat_sel matches no entry.
  always_comb begin
    ball_sh_d  = ball_we  ? ball_in  : ball_sh_q;
    cball_sh_d = cball_we ? cball_in : cball_sh_q;
    pcol_sh_d  = pcol_sh_q;
    ppos_sh_d  = ppos_sh_q;
    plat_hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_PLATS; i++) begin
      if (plat_we && (plat_sel == SEL_W'(i))) begin
        plat_hit_c                      = 1'b1;
        pcol_sh_d[i*COLOR_W +: COLOR_W] = plat_color_in;
        ppos_sh_d[i*POS_W +: POS_W]     = plat_pos_in;
      end
    end
    score_sh_d = score_sh_q;
    if (score_clr)                                 score_sh_d = '0;
    else if (score_inc && score_sh_q != SCORE_MAX) score_sh_d = score_sh_q + SCORE_W'(1);
    // A write in the commit cycle keeps dirty set, since it misses that commit.
    dirty_d = (ball_we | cball_we | plat_hit_c | score_inc | score_clr) |
              (dirty_q & ~commit_fire_c);
  end

  // Shadow and committed copies; commit publishes the pre-write shadow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ball_sh_q     <= '0;
      cball_sh_q    <= '0;
      pcol_sh_q     <= '0;
      ppos_sh_q     <= '0;
      score_sh_q    <= '0;
      dirty_q       <= 1'b0;
      ack_q         <= 1'b0;
      prev_ball_q   <= '0;
      curr_ball_q   <= '0;
      color_ball_q  <= '0;
      color_plats_q <= '0;
      pos_plats_q   <= '0;
      score_q       <= '0;
    end else begin
      ball_sh_q  <= ball_sh_d;
      cball_sh_q <= cball_sh_d;
      pcol_sh_q  <= pcol_sh_d;
      ppos_sh_q  <= ppos_sh_d;
      score_sh_q <= score_sh_d;
      dirty_q    <= dirty_d;
      ack_q      <= commit_fire_c;
      if (commit_fire_c) begin
        prev_ball_q   <= curr_ball_q;
        curr_ball_q   <= ball_sh_q;
        color_ball_q  <= cball_sh_q;
        color_plats_q <= pcol_sh_q;
        pos_plats_q   <= ppos_sh_q;
        score_q       <= score_sh_q;
      end
    end
  end

  assign commit_ack         = ack_q;
  assign dirty              = dirty_q;
  assign prev_ball_out      = prev_ball_q;
  assign curr_ball_out      = curr_ball_q;
  assign color_ball_out     = color_ball_q;
  assign color_plats_out    = color_plats_q;
  assign position_plats_out = pos_plats_q;
  assign score_out          = score_q;

endmodule

// File: tb/tb_game_state_bank.sv
// Testbench for game_state_bank: directed scenarios plus randomized traffic
// checked against a transaction-level model of shadow/committed copies.
module tb_game_state_bank;

  localparam int unsigned NP = 4;
  localparam int unsigned SMAX = 4095;

  logic clk, resetn;
  logic ball_we, cball_we, plat_we, score_inc, score_clr, commit_req;
  logic [7:0] ball_in;
  logic [2:0] cball_in, plat_color_in;
  logic [1:0] plat_sel;
  logic [6:0] plat_pos_in;

  logic        commit_ack, dirty;
  logic [7:0]  prev_ball_out, curr_ball_out;
  logic [2:0]  color_ball_out;
  logic [11:0] color_plats_out;
  logic [27:0] position_plats_out;
  logic [11:0] score_out;

  logic        ack3, dirty3;
  logic [7:0]  prev3, curr3;
  logic [2:0]  cball3;
  logic [8:0]  pcol3;
  logic [20:0] ppos3;
  logic [11:0] score3;

  int n_cmp, n_fail;

  // Reference model: shadow copy, committed copy, request edge tracking.
  logic [7:0] s_ball, m_prev, m_curr;
  logic [2:0] s_cball, m_cball;
  logic [2:0] s_pc [NP];
  logic [6:0] s_pp [NP];
  logic [2:0] m_pc [NP];
  logic [6:0] m_pp [NP];
  int         s_score, m_score;
  bit         m_dirty, m_ack, m_prev_req;

  game_state_bank dut (
    .clk(clk), .resetn(resetn),
    .ball_we(ball_we), .ball_in(ball_in),
    .cball_we(cball_we), .cball_in(cball_in),
    .plat_we(plat_we), .plat_sel(plat_sel),
    .plat_color_in(plat_color_in), .plat_pos_in(plat_pos_in),
    .score_inc(score_inc), .score_clr(score_clr),
    .commit_req(commit_req), .commit_ack(commit_ack), .dirty(dirty),
    .prev_ball_out(prev_ball_out), .curr_ball_out(curr_ball_out),
    .color_ball_out(color_ball_out), .color_plats_out(color_plats_out),
    .position_plats_out(position_plats_out), .score_out(score_out)
  );

  game_state_bank #(.NUM_PLATS(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .ball_we(ball_we), .ball_in(ball_in),
    .cball_we(cball_we), .cball_in(cball_in),
    .plat_we(plat_we), .plat_sel(plat_sel),
    .plat_color_in(plat_color_in), .plat_pos_in(plat_pos_in),
    .score_inc(score_inc), .score_clr(score_clr),
    .commit_req(commit_req), .commit_ack(ack3), .dirty(dirty3),
    .prev_ball_out(prev3), .curr_ball_out(curr3),
    .color_ball_out(cball3), .color_plats_out(pcol3),
    .position_plats_out(ppos3), .score_out(score3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    s_ball = '0; m_prev = '0; m_curr = '0; s_cball = '0; m_cball = '0;
    for (int i = 0; i < NP; i++) begin
      s_pc[i] = '0; s_pp[i] = '0; m_pc[i] = '0; m_pp[i] = '0;
    end
    s_score = 0; m_score = 0; m_dirty = 0; m_ack = 0; m_prev_req = 0;
  endtask

  task automatic model_step();
    bit commit, wr;
    commit = commit_req && !m_prev_req;
    if (commit) begin
      m_prev = m_curr; m_curr = s_ball; m_cball = s_cball; m_score = s_score;
      for (int i = 0; i < NP; i++) begin m_pc[i] = s_pc[i]; m_pp[i] = s_pp[i]; end
    end
    m_ack = commit;
    wr = ball_we || cball_we || plat_we || score_inc || score_clr;
    m_dirty = wr ? 1'b1 : (commit ? 1'b0 : m_dirty);
    if (ball_we)  s_ball = ball_in;
    if (cball_we) s_cball = cball_in;
    if (plat_we) begin s_pc[plat_sel] = plat_color_in; s_pp[plat_sel] = plat_pos_in; end
    if (score_clr)      s_score = 0;
    else if (score_inc) s_score = (s_score + 1 > SMAX) ? SMAX : s_score + 1;
    m_prev_req = commit_req;
  endtask

  // Advance one clock; model follows the edge; return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    ball_we = 0; cball_we = 0; plat_we = 0; score_inc = 0; score_clr = 0;
    commit_req = 0; ball_in = '0; cball_in = '0; plat_sel = '0;
    plat_color_in = '0; plat_pos_in = '0;
  endtask

  task automatic do_commit();
    commit_req = 1; tick();
    commit_req = 0; tick();
  endtask

  task automatic test_reset();
    drive_idle();
    resetn = 0;
    model_reset();
    #12;
    n_cmp++; if (curr_ball_out !== 8'h00 || score_out !== 12'h000 || dirty !== 1'b0 || commit_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_init curr=%h score=%h dirty=%b ack=%b required 0", curr_ball_out, score_out, dirty, commit_ack);
    end
    @(negedge clk); resetn = 1;
    ball_we = 1; ball_in = 8'hAB; score_inc = 1; tick();
    ball_we = 0; score_inc = 0;
    do_commit();
    ball_we = 1; ball_in = 8'hCD; tick(); ball_we = 0;
    n_cmp++; if (curr_ball_out !== 8'hAB || dirty !== 1'b1) begin
      n_fail++; $display("FAIL reset_precond curr=%h dirty=%b required AB/1", curr_ball_out, dirty);
    end
    #2 resetn = 0;
    #1;
    n_cmp++; if (curr_ball_out !== 8'h00 || prev_ball_out !== 8'h00 || score_out !== 12'h000 ||
                 dirty !== 1'b0 || commit_ack !== 1'b0 || color_plats_out !== 12'h000) begin
      n_fail++; $display("FAIL reset_async curr=%h prev=%h score=%h dirty=%b ack=%b required all 0", curr_ball_out, prev_ball_out, score_out, dirty, commit_ack);
    end
    model_reset();
    @(negedge clk);
    resetn = 1; commit_req = 1; tick();
    n_cmp++; if (commit_ack !== 1'b1 || curr_ball_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_release_commit ack=%b curr=%h required 1/00", commit_ack, curr_ball_out);
    end
    commit_req = 0; tick();
  endtask

  task automatic test_platforms();
    plat_we = 1; plat_sel = 2'd2; plat_color_in = 3'd5; plat_pos_in = 7'h3A; tick();
    plat_we = 0;
    n_cmp++; if (dirty !== 1'b1 || color_plats_out !== 12'h000) begin
      n_fail++; $display("FAIL plat_shadow dirty=%b colors=%h required 1/000", dirty, color_plats_out);
    end
    do_commit();
    n_cmp++; if (color_plats_out !== 12'h140 || position_plats_out !== 28'h00E8000 || dirty !== 1'b0) begin
      n_fail++; $display("FAIL plat_commit colors=%h pos=%h dirty=%b required 140/00E8000/0", color_plats_out, position_plats_out, dirty);
    end
  endtask

  task automatic test_invalid_sel();
    plat_we = 1; plat_sel = 2'd3; plat_color_in = 3'd7; plat_pos_in = 7'h7F; tick();
    plat_we = 0;
    n_cmp++; if (dirty3 !== 1'b0 || dirty !== 1'b1) begin
      n_fail++; $display("FAIL invalid_sel_dirty dirty3=%b dirty4=%b required 0/1", dirty3, dirty);
    end
    do_commit();
    n_cmp++; if (pcol3 !== 9'h140 || ppos3 !== 21'h0E8000 || position_plats_out !== 28'hFEE8000) begin
      n_fail++; $display("FAIL invalid_sel_commit pcol3=%h ppos3=%h pos4=%h required 140/0E8000/FEE8000", pcol3, ppos3, position_plats_out);
    end
  endtask

  task automatic test_basic_commit();
    ball_we = 1; ball_in = 8'h12; tick(); ball_we = 0;
    do_commit();
    ball_we = 1; ball_in = 8'h34; tick(); ball_we = 0;
    commit_req = 1; tick();
    n_cmp++; if (commit_ack !== 1'b1 || prev_ball_out !== 8'h12 || curr_ball_out !== 8'h34) begin
      n_fail++; $display("FAIL basic_commit ack=%b prev=%h curr=%h required 1/12/34", commit_ack, prev_ball_out, curr_ball_out);
    end
    commit_req = 0;
    ball_we = 1; ball_in = 8'h77; cball_we = 1; cball_in = 3'd3;
    for (int i = 0; i < 3; i++) tick();
    ball_we = 0; cball_we = 0;
    n_cmp++; if (curr_ball_out !== 8'h34 || color_ball_out !== 3'd0 || dirty !== 1'b1 || commit_ack !== 1'b0) begin
      n_fail++; $display("FAIL basic_stable curr=%h cball=%h dirty=%b ack=%b required 34/0/1/0", curr_ball_out, color_ball_out, dirty, commit_ack);
    end
  endtask

  task automatic test_score();
    score_clr = 1; tick(); score_clr = 0;
    score_inc = 1;
    for (int i = 0; i < 4100; i++) tick();
    score_inc = 0;
    do_commit();
    n_cmp++; if (score_out !== 12'd4095) begin
      n_fail++; $display("FAIL score_saturate got=%0d required 4095", score_out);
    end
    score_clr = 1; score_inc = 1; tick(); score_clr = 0; score_inc = 0;
    do_commit();
    n_cmp++; if (score_out !== 12'd0) begin
      n_fail++; $display("FAIL score_clr_priority got=%0d required 0", score_out);
    end
  endtask

  task automatic test_handshake();
    int acks;
    logic last_ack;
    bit back_to_back;
    acks = 0; last_ack = 0; back_to_back = 0;
    commit_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (commit_ack === 1'b1) begin acks++; if (last_ack) back_to_back = 1; end
      last_ack = commit_ack;
    end
    n_cmp++; if (acks !== 1 || back_to_back) begin
      n_fail++; $display("FAIL hold_one_ack acks=%0d required 1", acks);
    end
    commit_req = 0; tick();
    commit_req = 1; tick();
    n_cmp++; if (commit_ack !== 1'b1) begin
      n_fail++; $display("FAIL reraise_ack ack=%b required 1", commit_ack);
    end
    commit_req = 0; tick();
    ball_we = 1; ball_in = 8'h21; tick(); ball_we = 0;
    do_commit();
    ball_we = 1; ball_in = 8'h55; commit_req = 1; tick(); ball_we = 0;
    n_cmp++; if (commit_ack !== 1'b1 || curr_ball_out !== 8'h21 || dirty !== 1'b1) begin
      n_fail++; $display("FAIL write_on_commit ack=%b curr=%h dirty=%b required 1/21/1", commit_ack, curr_ball_out, dirty);
    end
    commit_req = 0; tick();
    commit_req = 1; tick(); commit_req = 0;
    n_cmp++; if (curr_ball_out !== 8'h55 || prev_ball_out !== 8'h21 || dirty !== 1'b0) begin
      n_fail++; $display("FAIL next_commit curr=%h prev=%h dirty=%b required 55/21/0", curr_ball_out, prev_ball_out, dirty);
    end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] exp_pc;
    logic [27:0] exp_pp;
    for (int c = 0; c < 600; c++) begin
      ball_we = ($urandom_range(0, 3) == 0); ball_in = 8'($urandom);
      cball_we = ($urandom_range(0, 3) == 0); cball_in = 3'($urandom);
      plat_we = ($urandom_range(0, 3) == 0); plat_sel = 2'($urandom);
      plat_color_in = 3'($urandom); plat_pos_in = 7'($urandom);
      score_inc = ($urandom_range(0, 1) == 0); score_clr = ($urandom_range(0, 15) == 0);
      commit_req = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        ball_we = 0; cball_we = 0; plat_we = 0; score_inc = 0; score_clr = 0;
      end
      tick();
      for (int i = 0; i < NP; i++) begin
        exp_pc[i*3 +: 3] = m_pc[i];
        exp_pp[i*7 +: 7] = m_pp[i];
      end
      n_cmp++;
      if (commit_ack !== m_ack || dirty !== m_dirty || prev_ball_out !== m_prev ||
          curr_ball_out !== m_curr || color_ball_out !== m_cball ||
          color_plats_out !== exp_pc || position_plats_out !== exp_pp ||
          score_out !== 12'(m_score)) begin
        n_fail++;
        $display("FAIL random[%0d] ack=%b/%b dirty=%b/%b prev=%h/%h curr=%h/%h cb=%h/%h pc=%h/%h pp=%h/%h score=%0d/%0d (got/required)",
                 c, commit_ack, m_ack, dirty, m_dirty, prev_ball_out, m_prev, curr_ball_out, m_curr,
                 color_ball_out, m_cball, color_plats_out, exp_pc, position_plats_out, exp_pp, score_out, m_score);
      end
    end
    drive_idle();
    tick();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_platforms();
    test_invalid_sel();
    test_basic_commit();
    test_score();
    test_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
